// File: rtl/ep2_cmd_parser_pkg.sv
// ---------------------------------------------------------------------------
// ep2_pkg
// Shared definitions for the EP2 (host-to-radio) command parser:
//   - ep2_state_t     : frame parser state encoding
//   - EP2_SYNC_BYTE   : sync byte value (sent three times per frame)
//   - EP2_HDR_BYTES   : sync + C0..C4 bytes at the head of every frame
//   - EP2_FRAME_BYTES : total bytes per EP2 frame
// ---------------------------------------------------------------------------
package ep2_pkg;

  localparam logic [7:0] EP2_SYNC_BYTE   = 8'h7F;
  localparam int         EP2_HDR_BYTES   = 8;
  localparam int         EP2_FRAME_BYTES = 512;

  // ST_HUNT doubles as "expect sync byte 0" when the parser is locked.
  typedef enum logic [3:0] {
    ST_HUNT    = 4'd0,
    ST_S1      = 4'd1,
    ST_S2      = 4'd2,
    ST_C0      = 4'd3,
    ST_C1      = 4'd4,
    ST_C2      = 4'd5,
    ST_C3      = 4'd6,
    ST_C4      = 4'd7,
    ST_PAYLOAD = 4'd8
  } ep2_state_t;

endpackage : ep2_pkg

// File: rtl/ep2_cmd_parser_if.sv
// ---------------------------------------------------------------------------
// ep2_cmd_parser_if
// Bundles the EP2 parser stream input, command output, payload output and
// status signals.
//   modport slave  : the parser (consumes ep2_*, drives cmd_*, pl_*, status)
//   modport master : the host side / environment (drives ep2_*)
// Signals:
//   ep2_data[7:0], ep2_valid, ep2_sop        input byte stream
//   cmd_addr[5:0], cmd_ptt, cmd_requires_resp,
//   cmd_data[31:0], cmd_rqst                 command interface to control
//   pl_data[7:0], pl_valid, pl_sof           payload bytes to TX path
//   in_sync, sync_err[7:0]                   lock status / error count
// ---------------------------------------------------------------------------
interface ep2_cmd_parser_if;

  logic [7:0]  ep2_data;
  logic        ep2_valid;
  logic        ep2_sop;

  logic [5:0]  cmd_addr;
  logic        cmd_ptt;
  logic        cmd_requires_resp;
  logic [31:0] cmd_data;
  logic        cmd_rqst;

  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_sof;

  logic        in_sync;
  logic [7:0]  sync_err;

  modport slave (
    input  ep2_data, ep2_valid, ep2_sop,
    output cmd_addr, cmd_ptt, cmd_requires_resp, cmd_data, cmd_rqst,
    output pl_data, pl_valid, pl_sof,
    output in_sync, sync_err
  );

  modport master (
    output ep2_data, ep2_valid, ep2_sop,
    input  cmd_addr, cmd_ptt, cmd_requires_resp, cmd_data, cmd_rqst,
    input  pl_data, pl_valid, pl_sof,
    input  in_sync, sync_err
  );

endinterface : ep2_cmd_parser_if

// File: rtl/ep2_cmd_parser.sv
// ---------------------------------------------------------------------------
// ep2_cmd_parser
// Locks onto the 0x7F7F7F sync of each EP2 frame, captures C0..C4 into a
// single-cycle cmd_rqst for the control block and forwards the remaining
// payload bytes downstream with a one-cycle registered latency.
//
// Ports:
//   clk  : block clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : ep2_cmd_parser_if.slave (stream in, command/payload/status out)
// Parameters:
//   FRAME_BYTES : bytes per frame including sync and C0..C4
//   SYNC_BYTE   : sync byte value
// Build option:
//   EP2_SYNCERR_EN : when defined, sync_err is a saturating 8-bit count of
//                    sync errors; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module ep2_cmd_parser
  import ep2_pkg::*;
#(
  parameter int         FRAME_BYTES = EP2_FRAME_BYTES,
  parameter logic [7:0] SYNC_BYTE   = EP2_SYNC_BYTE
) (
  input  logic                clk,
  input  logic                rst,
  ep2_cmd_parser_if.slave     bus
);

  localparam logic [8:0] HDR_IDX  = 9'(EP2_HDR_BYTES);
  localparam logic [8:0] LAST_IDX = 9'(FRAME_BYTES - 1);

  ep2_state_t  state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;

  // C0..C3 shadows; C4 is taken straight from the bus on the final byte.
  logic [7:0]  c0_q, c0_d;
  logic [7:0]  c1_q, c1_d;
  logic [7:0]  c2_q, c2_d;
  logic [7:0]  c3_q, c3_d;

  logic [5:0]  cmd_addr_q, cmd_addr_d;
  logic        cmd_ptt_q, cmd_ptt_d;
  logic        cmd_resp_q, cmd_resp_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic        cmd_rqst_q, cmd_rqst_d;

  logic [7:0]  pl_data_q, pl_data_d;
  logic        pl_valid_q, pl_valid_d;
  logic        pl_sof_q, pl_sof_d;

  logic        in_sync_q, in_sync_d;
  logic        sync_ev;
  logic        is_sync;

  assign is_sync = (bus.ep2_data == SYNC_BYTE);

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    c0_d       = c0_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    c3_d       = c3_q;
    cmd_addr_d = cmd_addr_q;
    cmd_ptt_d  = cmd_ptt_q;
    cmd_resp_d = cmd_resp_q;
    cmd_data_d = cmd_data_q;
    cmd_rqst_d = 1'b0;
    pl_data_d  = pl_data_q;
    pl_valid_d = 1'b0;
    pl_sof_d   = 1'b0;
    in_sync_d  = in_sync_q;
    sync_ev    = 1'b0;

    if (bus.ep2_valid) begin
      if (bus.ep2_sop) begin
        // SOP byte is sync byte 0 whatever its value; anything in flight
        // (including a partial C0..C4 capture) is abandoned.
        state_d = ST_S1;
        cnt_d   = '0;
        if (state_q != ST_HUNT) begin
          sync_ev = 1'b1;
        end
      end else begin
        unique case (state_q)
          ST_HUNT: begin
            if (is_sync) begin
              state_d = ST_S1;
            end else if (in_sync_q) begin
              // Locked: the frame boundary must start with sync.
              sync_ev = 1'b1;
            end
          end
          ST_S1: begin
            if (is_sync) begin
              state_d = ST_S2;
            end else begin
              sync_ev = 1'b1;
              state_d = ST_HUNT;
            end
          end
          ST_S2: begin
            if (is_sync) begin
              state_d   = ST_C0;
              in_sync_d = 1'b1;
            end else begin
              sync_ev = 1'b1;
              state_d = ST_HUNT;
            end
          end
          ST_C0: begin
            c0_d    = bus.ep2_data;
            state_d = ST_C1;
          end
          ST_C1: begin
            c1_d    = bus.ep2_data;
            state_d = ST_C2;
          end
          ST_C2: begin
            c2_d    = bus.ep2_data;
            state_d = ST_C3;
          end
          ST_C3: begin
            c3_d    = bus.ep2_data;
            state_d = ST_C4;
          end
          ST_C4: begin
            cmd_addr_d = c0_q[6:1];
            cmd_ptt_d  = c0_q[0];
            cmd_resp_d = c0_q[7];
            cmd_data_d = {c1_q, c2_q, c3_q, bus.ep2_data};
            cmd_rqst_d = 1'b1;
            cnt_d      = HDR_IDX;
            state_d    = ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            pl_valid_d = 1'b1;
            pl_data_d  = bus.ep2_data;
            pl_sof_d   = (cnt_q == HDR_IDX);
            if (cnt_q == LAST_IDX) begin
              // Frame complete: wait for the next sync while staying locked.
              cnt_d   = '0;
              state_d = ST_HUNT;
            end else begin
              cnt_d = cnt_q + 9'd1;
            end
          end
          default: begin
            state_d = ST_HUNT;
            cnt_d   = '0;
          end
        endcase
      end

      if (sync_ev) begin
        in_sync_d = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      cnt_q      <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      c3_q       <= '0;
      cmd_addr_q <= '0;
      cmd_ptt_q  <= 1'b0;
      cmd_resp_q <= 1'b0;
      cmd_data_q <= '0;
      cmd_rqst_q <= 1'b0;
      pl_data_q  <= '0;
      pl_valid_q <= 1'b0;
      pl_sof_q   <= 1'b0;
      in_sync_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      c0_q       <= c0_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      c3_q       <= c3_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_ptt_q  <= cmd_ptt_d;
      cmd_resp_q <= cmd_resp_d;
      cmd_data_q <= cmd_data_d;
      cmd_rqst_q <= cmd_rqst_d;
      pl_data_q  <= pl_data_d;
      pl_valid_q <= pl_valid_d;
      pl_sof_q   <= pl_sof_d;
      in_sync_q  <= in_sync_d;
    end
  end

  // -------------------------------------------------------------------------
  // Sync error counter
  // -------------------------------------------------------------------------
`ifdef EP2_SYNCERR_EN
  logic [7:0] sync_err_q, sync_err_d;

  always_comb begin
    sync_err_d = sync_err_q;
    if (sync_ev && (sync_err_q != 8'hFF)) begin
      sync_err_d = sync_err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err_q <= '0;
    end else begin
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.sync_err = sync_err_q;
`else
  // Error events only feed in_sync in this build.
  logic unused_sync_ev;
  assign unused_sync_ev = sync_ev;
  assign bus.sync_err   = 8'h00;
`endif

  assign bus.cmd_addr          = cmd_addr_q;
  assign bus.cmd_ptt           = cmd_ptt_q;
  assign bus.cmd_requires_resp = cmd_resp_q;
  assign bus.cmd_data          = cmd_data_q;
  assign bus.cmd_rqst          = cmd_rqst_q;
  assign bus.pl_data           = pl_data_q;
  assign bus.pl_valid          = pl_valid_q;
  assign bus.pl_sof            = pl_sof_q;
  assign bus.in_sync           = in_sync_q;

endmodule : ep2_cmd_parser

// File: tb/tb_ep2_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_ep2_cmd_parser
// Scoreboard bench for ep2_cmd_parser: expected commands and payload bytes
// are queued as stimulus is driven and popped as the parser emits them.
// Honors EP2_SYNCERR_EN for the expected sync_err value.
// ---------------------------------------------------------------------------
module tb_ep2_cmd_parser;

  logic clk;
  logic rst;

  ep2_cmd_parser_if bus ();

  ep2_cmd_parser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  addr;
    logic        ptt;
    logic        resp;
    logic [31:0] data;
    logic [31:0] neg;
  } cmd_exp_t;

  typedef struct packed {
    logic [7:0]  d;
    logic        sof;
    logic [31:0] neg;
  } pl_exp_t;

  cmd_exp_t cmd_q[$];
  pl_exp_t  pl_q[$];
  int       rq_times[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int neg_cnt      = 0;
  int exp_serr     = 0;

  cmd_exp_t ce;
  pl_exp_t  pe;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic note_err();
`ifdef EP2_SYNCERR_EN
    if (exp_serr < 255) exp_serr++;
`endif
  endtask

  // Output monitor: compare every emitted command / payload byte.
  always @(negedge clk) begin
    neg_cnt++;
    if (bus.cmd_rqst) begin
      rq_times.push_back(neg_cnt);
      if (cmd_q.size() == 0) begin
        check_val("cmd_unexpected", 32'd1, 32'd0);
      end else begin
        ce = cmd_q.pop_front();
        check_val("cmd_addr", {26'd0, bus.cmd_addr}, {26'd0, ce.addr});
        check_val("cmd_ptt", {31'd0, bus.cmd_ptt}, {31'd0, ce.ptt});
        check_val("cmd_resp", {31'd0, bus.cmd_requires_resp}, {31'd0, ce.resp});
        check_val("cmd_data", bus.cmd_data, ce.data);
        check_val("cmd_time", neg_cnt, ce.neg);
      end
    end
    if (bus.pl_valid) begin
      if (pl_q.size() == 0) begin
        check_val("pl_unexpected", 32'd1, 32'd0);
      end else begin
        pe = pl_q.pop_front();
        check_val("pl_data", {24'd0, bus.pl_data}, {24'd0, pe.d});
        check_val("pl_sof", {31'd0, bus.pl_sof}, {31'd0, pe.sof});
        check_val("pl_time", neg_cnt, pe.neg);
      end
    end
  end

  // Drive one byte, optionally preceded by 0..gap_max idle cycles.
  task automatic send_byte(input logic [7:0] d, input bit sop, input int gap_max,
                           output int drv_neg);
    int gaps;
    gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    repeat (gaps) begin
      bus.ep2_valid = 1'b0;
      bus.ep2_data  = 8'($urandom);
      bus.ep2_sop   = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.ep2_data  = d;
    bus.ep2_valid = 1'b1;
    bus.ep2_sop   = sop;
    drv_neg       = neg_cnt;
    @(posedge clk); #1;
    bus.ep2_valid = 1'b0;
    bus.ep2_sop   = 1'b0;
  endtask

  function automatic logic [7:0] pay_byte(input int seed, input int i);
    return 8'(seed * 37 + i * 3) ^ 8'(i >> 3);
  endfunction

  task automatic send_frame(input logic [7:0] c0, input logic [31:0] cdata,
                            input int seed, input int gap_max, input bit sop_first);
    int n;
    cmd_exp_t c;
    pl_exp_t  p;
    send_byte(8'h7F, sop_first, gap_max, n);
    send_byte(8'h7F, 1'b0, gap_max, n);
    send_byte(8'h7F, 1'b0, gap_max, n);
    send_byte(c0, 1'b0, gap_max, n);
    send_byte(cdata[31:24], 1'b0, gap_max, n);
    send_byte(cdata[23:16], 1'b0, gap_max, n);
    send_byte(cdata[15:8], 1'b0, gap_max, n);
    send_byte(cdata[7:0], 1'b0, gap_max, n);
    c.addr = c0[6:1];
    c.ptt  = c0[0];
    c.resp = c0[7];
    c.data = cdata;
    c.neg  = 32'(n + 2);
    cmd_q.push_back(c);
    for (int i = 0; i < 504; i++) begin
      p.d   = pay_byte(seed, i);
      p.sof = (i == 0);
      send_byte(p.d, 1'b0, gap_max, n);
      p.neg = 32'(n + 2);
      pl_q.push_back(p);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.ep2_data  = 8'h00;
    bus.ep2_valid = 1'b0;
    bus.ep2_sop   = 1'b0;
    idle(3);

    // Reset state
    check_val("rst_cmd_rqst", {31'd0, bus.cmd_rqst}, 32'd0);
    check_val("rst_cmd_data", bus.cmd_data, 32'd0);
    check_val("rst_cmd_addr", {26'd0, bus.cmd_addr}, 32'd0);
    check_val("rst_pl_valid", {31'd0, bus.pl_valid}, 32'd0);
    check_val("rst_in_sync", {31'd0, bus.in_sync}, 32'd0);
    check_val("rst_sync_err", {24'd0, bus.sync_err}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Locked frame A then back-to-back frame B
    send_frame(8'h93, 32'h12345678, 1, 0, 1'b1);
    send_frame(8'h2A, 32'hDEADBEEF, 2, 0, 1'b0);
    idle(2);
    check_val("b2b_in_sync", {31'd0, bus.in_sync}, 32'd1);
    check_val("b2b_count", rq_times.size(), 32'd2);
    if (rq_times.size() >= 2)
      check_val("b2b_spacing", 32'(rq_times[1] - rq_times[0]), 32'd512);
    check_val("cmd_hold", bus.cmd_data, 32'hDEADBEEF);
    check_val("b2b_sync_err", {24'd0, bus.sync_err}, 32'(exp_serr));

    // Corrupt third sync byte
    send_byte(8'h7F, 1'b0, 0, n);
    send_byte(8'h7F, 1'b0, 0, n);
    send_byte(8'h00, 1'b0, 0, n);
    note_err();
    idle(2);
    check_val("bad_sync_in_sync", {31'd0, bus.in_sync}, 32'd0);
    check_val("bad_sync_err", {24'd0, bus.sync_err}, 32'(exp_serr));
    send_frame(8'h04, 32'h0000FFFF, 3, 0, 1'b0);
    idle(2);
    check_val("relock_in_sync", {31'd0, bus.in_sync}, 32'd1);

    // SOP after C2: partial command discarded
    send_byte(8'h7F, 1'b1, 0, n);
    send_byte(8'h7F, 1'b0, 0, n);
    send_byte(8'h7F, 1'b0, 0, n);
    send_byte(8'h55, 1'b0, 0, n);
    send_byte(8'hAA, 1'b0, 0, n);
    send_byte(8'hBB, 1'b0, 0, n);
    note_err();
    send_frame(8'hC1, 32'hCAFEF00D, 4, 0, 1'b1);
    idle(2);
    check_val("sop_sync_err", {24'd0, bus.sync_err}, 32'(exp_serr));
    check_val("sop_in_sync", {31'd0, bus.in_sync}, 32'd1);

    // Same content as frame A with random valid gaps
    send_frame(8'h93, 32'h12345678, 1, 2, 1'b0);
    idle(2);
    check_val("gap_in_sync", {31'd0, bus.in_sync}, 32'd1);

    // Reset right after C4 is accepted: the pending cmd_rqst must vanish
    send_byte(8'h7F, 1'b0, 0, n);
    send_byte(8'h7F, 1'b0, 0, n);
    send_byte(8'h7F, 1'b0, 0, n);
    send_byte(8'h11, 1'b0, 0, n);
    send_byte(8'h22, 1'b0, 0, n);
    send_byte(8'h33, 1'b0, 0, n);
    send_byte(8'h44, 1'b0, 0, n);
    send_byte(8'h66, 1'b0, 0, n);
    rst = 1'b1;
    #1;
    check_val("midrst_cmd_rqst", {31'd0, bus.cmd_rqst}, 32'd0);
    check_val("midrst_cmd_data", bus.cmd_data, 32'd0);
    check_val("midrst_in_sync", {31'd0, bus.in_sync}, 32'd0);
    check_val("midrst_sync_err", {24'd0, bus.sync_err}, 32'd0);
    exp_serr = 0;
    idle(2);
    rst = 1'b0;
    idle(1);
    send_frame(8'h80, 32'h01020304, 5, 0, 1'b0);
    idle(2);
    check_val("post_rst_in_sync", {31'd0, bus.in_sync}, 32'd1);

    // 300 bad frames: saturate the error counter
    for (int k = 0; k < 300; k++) begin
      send_byte(8'h7F, 1'b0, 0, n);
      send_byte(8'h00, 1'b0, 0, n);
      note_err();
    end
    idle(2);
    check_val("sat_sync_err", {24'd0, bus.sync_err}, 32'(exp_serr));
    check_val("sat_in_sync", {31'd0, bus.in_sync}, 32'd0);

    idle(5);
    check_val("cmd_q_drained", cmd_q.size(), 32'd0);
    check_val("pl_q_drained", pl_q.size(), 32'd0);
    check_val("rqst_total", rq_times.size(), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ep2_cmd_parser

// File: doc/ep2_cmd_parser.md
# ep2_cmd_parser

Extracts Protocol-1 command/control words from the host-to-radio (EP2) byte stream and feeds the `control` block's command interface. For each 512-byte frame it:
- finds the 0x7F7F7F sync,
- captures C0..C4 and issues one `cmd_rqst` pulse,
- forwards the 504 payload bytes downstream to the TX IQ/audio path.

It sits between the UDP receive path and `control`/TX FIFO, in the 2.5 MHz `clk` domain.

## Interface
- `FRAME_BYTES`, 512: bytes per EP2 frame, counting sync and C0..C4.
- `SYNC_BYTE`, 8'h7F: sync byte value, repeated 3 times.
- `clk`  in  1  block clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ep2_data`  in  8  stream byte.
- `ep2_valid`  in  1  `ep2_data` valid this cycle.
- `ep2_sop`  in  1  with `ep2_valid`: first byte of a new frame (forces resync).
- `cmd_addr`  out  6  C0[6:1].
- `cmd_ptt`  out  1  C0[0].
- `cmd_requires_resp`  out  1  C0[7].
- `cmd_data`  out  32  {C1,C2,C3,C4}.
- `cmd_rqst`  out  1  one-cycle pulse; `cmd_*` fields valid.
- `pl_data`  out  8  payload byte.
- `pl_valid`  out  1  payload byte strobe.
- `pl_sof`  out  1  with `pl_valid`: first payload byte of a frame.
- `in_sync`  out  1  parser is locked to frame boundaries.
- `sync_err`  out  8  saturating sync-error count (see Configuration).

## Operation
- States: HUNT, S1, S2, C0, C1, C2, C3, C4, PAYLOAD.
- Bytes advance state only when `ep2_valid`=1.
- HUNT: byte==SYNC_BYTE → S1; otherwise stay.
- S1, S2: byte==SYNC_BYTE → next state; otherwise count a sync error and go to HUNT.
- C0..C4: capture into shadow registers; after C4 go to PAYLOAD.
- Shadow registers copy to the `cmd_*` outputs on the C4 byte.
- PAYLOAD: forward each byte to `pl_*`.
- Byte counter 9 bits, reset to 8 on entering PAYLOAD. After byte FRAME_BYTES-1, return to S0-expect (HUNT with `in_sync` kept).
- Locked frame: first byte not SYNC_BYTE → sync error, `in_sync`←0, HUNT.
- `in_sync`: set on reaching C0; cleared on any sync error.
- `ep2_sop`=1 with `ep2_valid`:
  - the byte is treated as sync byte 0 regardless of state;
  - mid-frame (state not HUNT/S0) counts a sync error;
  - a partial C0..C4 capture is discarded and no `cmd_rqst` is issued.
- `cmd_*` fields hold their value until the next `cmd_rqst`.

## Timing
- Reset values: all outputs 0; state HUNT; counter 0.
- `cmd_rqst`: exactly 1 cycle after the cycle C4 is accepted, with `cmd_*` updated the same cycle.
- Commands are never dropped. Minimum spacing between `cmd_rqst` pulses is FRAME_BYTES valid bytes.
- `pl_valid`/`pl_data`: registered, 1-cycle latency from input; no backpressure.
- `ep2_valid` may be high every cycle; gaps are allowed anywhere and only stall the state.
- Reset asserted mid-frame: immediate return to HUNT; a pending `cmd_rqst` is cancelled.

## Configuration
- `EP2_SYNCERR_EN` defined:
  - `sync_err` is an 8-bit counter, +1 per sync error, saturating at 255;
  - cleared only by `rst`.
- Undefined: `sync_err` tied to 8'h00 and the counter is not synthesized. `in_sync` behaviour is unchanged.

## Structure
- Shared package `ep2_pkg`:
  - state enum `ep2_state_t`;
  - `EP2_SYNC_BYTE`, `EP2_HDR_BYTES` = 8, `EP2_FRAME_BYTES` = 512.
- No sub-module; the counter and FSM are one module.

## Test plan
- Locked frame: 7F 7F 7F, C0=8'h93, C1..C4=12 34 56 78, then 504 bytes →
  - `cmd_rqst` 1 cycle after C4;
  - `cmd_addr`=6'h09, `cmd_ptt`=1, `cmd_requires_resp`=1, `cmd_data`=32'h12345678;
  - 504 `pl_valid` strobes, `pl_sof` on the first.
- Back-to-back frames with `ep2_valid` held high → two `cmd_rqst` exactly 512 cycles apart; `in_sync` stays 1.
- Corrupt the third sync byte (7F 7F 00) → no `cmd_rqst`, `in_sync`=0, `sync_err`=1. The next good frame re-locks.
- `ep2_sop` asserted after C2 → partial command discarded, `sync_err`+1, new frame parsed normally.
- Random `ep2_valid` gaps (50% duty) in a frame → same `cmd_*` and payload content as the gapless run.
- 300 bad frames with `EP2_SYNCERR_EN` → `sync_err`=255. Without the macro → `sync_err`=0.
